// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - operand/result handshake bundle for the serial binary-to-BCD converter
interface bin_to_bcd_seq_if #(
  parameter int BITS   = 16,
  parameter int DIGITS = 6
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [BITS-1:0]       bin_in;
  logic                  in_sign;
  logic                  over;
  logic                  com;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  digit_ovf;
  logic                  busy;

  modport master (
    output in_valid, bin_in, in_sign, over, com, out_ready,
    input  in_ready, out_valid, bcd, digit_ovf, busy
  );

  modport slave (
    input  in_valid, bin_in, in_sign, over, com, out_ready,
    output in_ready, out_valid, bcd, digit_ovf, busy
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - serial double-dabble converter, one operand bit per clock
// Define BCD_TWOS_COMP_EN to treat bin_in as two's complement (sign from MSB, in_sign ignored).
module bin_to_bcd_seq #(
  parameter int BITS   = 16,
  parameter int DIGITS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  bin_to_bcd_seq_if.slave  io
);
  localparam int AW = 4 * (DIGITS - 1);
  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [BITS-1:0]       shreg_q;
  logic [AW-1:0]         acc_q;
  logic [CW-1:0]         cnt_q;
  logic                  neg_q, over_q, com_q, ovf_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  digit_ovf_q;

  logic                  accept, last_shift;
  logic                  neg_in;
  logic [BITS-1:0]       operand;
  logic [AW-1:0]         acc_adj, acc_next;
  logic                  carry, ovf_next;
  logic [3:0]            sign_nib;

  assign accept     = (state_q == S_IDLE) && io.in_valid;
  assign last_shift = (state_q == S_SHIFT) && (cnt_q == CW'(BITS - 1));

`ifdef BCD_TWOS_COMP_EN
  // Negating in BITS width keeps -2^(BITS-1) exact as an unsigned magnitude.
  assign neg_in  = io.bin_in[BITS-1];
  assign operand = neg_in ? ((~io.bin_in) + BITS'(1)) : io.bin_in;
`else
  assign neg_in  = io.in_sign;
  assign operand = io.bin_in;
`endif

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS - 1; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    // Anything pushed out of the top digit means the magnitude no longer fits.
    carry    = acc_adj[AW-1];
    acc_next = {acc_adj[AW-2:0], shreg_q[BITS-1]};
    ovf_next = ovf_q | carry;
    if ((com_q && over_q) || ovf_next) begin
      sign_nib = 4'hB;
    end else if (neg_q) begin
      sign_nib = 4'hA;
    end else begin
      sign_nib = 4'hC;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)       state_d = S_SHIFT;
      S_SHIFT: if (last_shift)   state_d = S_DONE;
      S_DONE:  if (io.out_ready) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      over_q      <= 1'b0;
      com_q       <= 1'b0;
      ovf_q       <= 1'b0;
      bcd_q       <= '0;
      digit_ovf_q <= 1'b0;
    end else if (accept) begin
      shreg_q <= operand;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= neg_in;
      over_q  <= io.over;
      com_q   <= io.com;
      ovf_q   <= 1'b0;
    end else if (state_q == S_SHIFT) begin
      shreg_q <= shreg_q << 1;
      acc_q   <= acc_next;
      cnt_q   <= cnt_q + CW'(1);
      ovf_q   <= ovf_next;
      // Result is captured on the final shift so it is already stable when DONE is entered.
      if (last_shift) begin
        bcd_q       <= {sign_nib, acc_next};
        digit_ovf_q <= ovf_next;
      end
    end
  end

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.busy      = (state_q != S_IDLE);
  assign io.bcd       = bcd_q;
  assign io.digit_ovf = digit_ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - randomized bench for bin_to_bcd_seq against a decimal-arithmetic model
module tb_bin_to_bcd_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bin_to_bcd_seq_if #(.BITS(16), .DIGITS(6)) io6 ();
  bin_to_bcd_seq_if #(.BITS(16), .DIGITS(4)) io4 ();

  bin_to_bcd_seq #(.BITS(16), .DIGITS(6)) u_dut6 (.clk(clk), .rst_n(rst_n), .io(io6.slave));
  bin_to_bcd_seq #(.BITS(16), .DIGITS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .io(io4.slave));

  always #5 clk = ~clk;

  // Expected result from plain decimal arithmetic; nd = number of magnitude digits.
  function automatic void ref_model(input int nd, input logic [15:0] b, input bit s, input bit ov,
                                    input bit cm, output logic [23:0] r, output bit ovf);
    longint mag, lim, m;
    bit neg;
    mag = longint'(b);
    neg = s;
`ifdef BCD_TWOS_COMP_EN
    neg = b[15];
    if (b[15]) mag = 65536 - mag;
`endif
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ovf = (mag >= lim);
    m = mag % lim;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    r[4*nd +: 4] = ((cm && ov) || ovf) ? 4'hB : (neg ? 4'hA : 4'hC);
  endfunction

  task automatic run_op(input bit sel, input logic [15:0] b, input bit s, input bit ov, input bit cm,
                        output int lat, output logic [23:0] res, output bit ovf, output bit busy_done);
    if (sel) begin
      io4.bin_in = b; io4.in_sign = s; io4.over = ov; io4.com = cm; io4.in_valid = 1'b1;
    end else begin
      io6.bin_in = b; io6.in_sign = s; io6.over = ov; io6.com = cm; io6.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    io4.in_valid = 1'b0;
    io6.in_valid = 1'b0;
    lat = 0;
    while (!(sel ? io4.out_valid : io6.out_valid) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res       = sel ? {8'h00, io4.bcd} : io6.bcd;
    ovf       = sel ? io4.digit_ovf : io6.digit_ovf;
    busy_done = sel ? io4.busy : io6.busy;
    if (sel) io4.out_ready = 1'b1; else io6.out_ready = 1'b1;
    @(posedge clk); #1;
    io4.out_ready = 1'b0;
    io6.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({io6.in_ready, io6.out_valid, io6.busy, io6.digit_ovf} !== 4'b1000 || io6.bcd !== 24'h0) begin
      failures++;
      $display("FAIL reset6 got rdy/vld/busy/ovf=%b bcd=%h expected 1000 bcd=000000",
               {io6.in_ready, io6.out_valid, io6.busy, io6.digit_ovf}, io6.bcd);
    end
    checks++;
    if ({io4.in_ready, io4.out_valid, io4.busy, io4.digit_ovf} !== 4'b1000 || io4.bcd !== 16'h0) begin
      failures++;
      $display("FAIL reset4 got rdy/vld/busy/ovf=%b bcd=%h expected 1000 bcd=0000",
               {io4.in_ready, io4.out_valid, io4.busy, io4.digit_ovf}, io4.bcd);
    end
  endtask

  task automatic test_directed();
    logic [15:0] vb [6] = '{16'h3039, 16'h3039, 16'h3039, 16'hFFFF, 16'h0000, 16'h0000};
    bit          vs [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bit          vo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bit          vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [23:0] res, exp_r;
    bit ovf, exp_o, bsy;
    int lat;
    for (int i = 0; i < 6; i++) begin
      ref_model(5, vb[i], vs[i], vo[i], vc[i], exp_r, exp_o);
      run_op(1'b0, vb[i], vs[i], vo[i], vc[i], lat, res, ovf, bsy);
      checks++;
      if (res !== exp_r || ovf !== exp_o) begin
        failures++;
        $display("FAIL directed6[%0d] got bcd=%h ovf=%b expected bcd=%h ovf=%b", i, res, ovf, exp_r, exp_o);
      end
      checks++;
      if (lat !== 16 || bsy !== 1'b1) begin
        failures++;
        $display("FAIL latency6[%0d] got lat=%0d busy=%b expected lat=16 busy=1", i, lat, bsy);
      end
    end
  endtask

  task automatic test_digit_ovf();
    logic [15:0] vb [4] = '{16'h03E8, 16'h03E7, 16'h0000, 16'h2710};
    logic [23:0] res, exp_r;
    bit ovf, exp_o, bsy;
    int lat;
    for (int i = 0; i < 4; i++) begin
      ref_model(3, vb[i], 1'b0, 1'b0, 1'b0, exp_r, exp_o);
      run_op(1'b1, vb[i], 1'b0, 1'b0, 1'b0, lat, res, ovf, bsy);
      checks++;
      if (res !== exp_r || ovf !== exp_o || lat !== 16) begin
        failures++;
        $display("FAIL digits4[%0d] got bcd=%h ovf=%b lat=%0d expected bcd=%h ovf=%b lat=16",
                 i, res, ovf, lat, exp_r, exp_o);
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] res, exp_r;
    logic [15:0] b;
    bit ovf, exp_o, bsy, s, ov, cm, sel;
    int lat;
    for (int n = 0; n < 60; n++) begin
      sel = (n % 3 == 2);
      b   = (sel && n % 2 == 0) ? 16'($urandom_range(900, 1100)) : 16'($urandom_range(0, 65535));
      s   = 1'($urandom_range(0, 1));
      ov  = 1'($urandom_range(0, 1));
      cm  = 1'($urandom_range(0, 1));
      ref_model(sel ? 3 : 5, b, s, ov, cm, exp_r, exp_o);
      run_op(sel, b, s, ov, cm, lat, res, ovf, bsy);
      checks++;
      if (res !== exp_r || ovf !== exp_o || lat !== 16) begin
        failures++;
        $display("FAIL random[%0d] dut%0d bin=%h got bcd=%h ovf=%b lat=%0d expected bcd=%h ovf=%b lat=16",
                 n, sel ? 4 : 6, b, res, ovf, lat, exp_r, exp_o);
      end
    end
  endtask

  task automatic test_stall();
    logic [23:0] exp_r;
    bit exp_o;
    int lat;
    ref_model(5, 16'd9876, 1'b1, 1'b0, 1'b0, exp_r, exp_o);
    io6.bin_in = 16'd9876; io6.in_sign = 1'b1; io6.over = 1'b0; io6.com = 1'b0; io6.in_valid = 1'b1;
    @(posedge clk); #1;
    io6.bin_in = 16'd1111; io6.in_sign = 1'b0;
    lat = 0;
    while (!io6.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL stall_latency got %0d expected 16", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (io6.bcd !== exp_r || io6.out_valid !== 1'b1 || io6.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d] got bcd=%h vld=%b rdy=%b expected bcd=%h vld=1 rdy=0",
                 c, io6.bcd, io6.out_valid, io6.in_ready, exp_r);
      end
    end
    io6.out_ready = 1'b1;
    @(posedge clk); #1;
    io6.in_valid  = 1'b0;
    io6.out_ready = 1'b0;
    checks++;
    if (io6.out_valid !== 1'b0 || io6.in_ready !== 1'b1 || io6.busy !== 1'b0 || io6.bcd !== exp_r) begin
      failures++;
      $display("FAIL stall_release got vld=%b rdy=%b busy=%b bcd=%h expected vld=0 rdy=1 busy=0 bcd=%h",
               io6.out_valid, io6.in_ready, io6.busy, io6.bcd, exp_r);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] res, exp_r;
    bit ovf, exp_o, bsy;
    int lat;
    io6.bin_in = 16'h1234; io6.in_sign = 1'b0; io6.over = 1'b0; io6.com = 1'b0; io6.in_valid = 1'b1;
    @(posedge clk); #1;
    io6.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (io6.in_ready !== 1'b1 || io6.out_valid !== 1'b0 || io6.busy !== 1'b0 || io6.bcd !== 24'h0) begin
      failures++;
      $display("FAIL reset_mid got rdy=%b vld=%b busy=%b bcd=%h expected rdy=1 vld=0 busy=0 bcd=000000",
               io6.in_ready, io6.out_valid, io6.busy, io6.bcd);
    end
    ref_model(5, 16'd4321, 1'b0, 1'b0, 1'b0, exp_r, exp_o);
    run_op(1'b0, 16'd4321, 1'b0, 1'b0, 1'b0, lat, res, ovf, bsy);
    checks++;
    if (res !== exp_r || ovf !== exp_o || lat !== 16) begin
      failures++;
      $display("FAIL after_reset got bcd=%h ovf=%b lat=%0d expected bcd=%h ovf=%b lat=16",
               res, ovf, lat, exp_r, exp_o);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    io6.in_valid = 1'b0; io6.bin_in = '0; io6.in_sign = 1'b0; io6.over = 1'b0; io6.com = 1'b0;
    io6.out_ready = 1'b0;
    io4.in_valid = 1'b0; io4.bin_in = '0; io4.in_sign = 1'b0; io4.over = 1'b0; io4.com = 1'b0;
    io4.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_digit_ovf();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
